// File: rtl/alu_tile_host_driver.sv
// Host-side driver for one ALU tile host port.
// Commands are queued, then issued one per host_in_valid pulse. Results are
// collected into a response queue. The number of ops in flight is capped so
// that every result has space waiting for it. A lost result times out.
module alu_tile_host_driver #(
   parameter int CMD_DEPTH = 4,
   parameter int RSP_DEPTH = 4,
   parameter int ISSUE_GAP = 0,
   parameter int TIMEOUT   = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cmd_valid,
   output logic                           cmd_ready,
   input  logic [63:0]                    cmd_a,
   input  logic [63:0]                    cmd_b,
   input  logic [15:0]                    cmd_ctrl,
   output logic [63:0]                    host_in_a,
   output logic [63:0]                    host_in_b,
   output logic [15:0]                    host_in_ctrl,
   output logic                           host_in_valid,
   input  logic [63:0]                    host_out_a,
   input  logic                           host_out_valid,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [63:0]                    rsp_data,
   output logic [$clog2(RSP_DEPTH+1)-1:0] outstanding,
   output logic [1:0]                     err,
   input  logic                           err_clr
);

   localparam int CP       = $clog2(CMD_DEPTH);
   localparam int CW       = $clog2(CMD_DEPTH + 1);
   localparam int RP       = $clog2(RSP_DEPTH);
   localparam int OW       = $clog2(RSP_DEPTH + 1);
   localparam int OW1      = OW + 1;
   localparam int TW       = $clog2(TIMEOUT + 1);
   localparam int GW       = (ISSUE_GAP > 0) ? $clog2(ISSUE_GAP + 1) : 1;
   localparam int GAP_LOAD = (ISSUE_GAP > 0) ? ISSUE_GAP - 1 : 0;

   typedef enum logic [1:0] {IDLE, SEND, GAP, ERR} state_t;

   state_t          state;
   state_t          state_nxt;

   // command queue
   logic [143:0]    cmd_mem [CMD_DEPTH];
   logic [CP-1:0]   cmd_wr_ptr;
   logic [CP-1:0]   cmd_rd_ptr;
   logic [CW-1:0]   cmd_count;
   logic            cmd_push;
   logic [143:0]    cmd_head;

   // response queue
   logic [63:0]     rsp_mem [RSP_DEPTH];
   logic [RP-1:0]   rsp_wr_ptr;
   logic [RP-1:0]   rsp_rd_ptr;
   logic [OW-1:0]   rsp_count;
   logic            rsp_push;
   logic            rsp_pop;

   logic [OW1-1:0]  credit_used;
   logic            eligible;
   logic            issue;
   logic            res_expected;
   logic            res_unexpected;
   logic            tmo_hit;
   logic            tmo_fire;
   logic [TW-1:0]   tmo_cnt;
   logic [GW-1:0]   gap_cnt;

   assign cmd_ready = (cmd_count != CW'(CMD_DEPTH));
   assign cmd_push  = cmd_valid && cmd_ready;
   assign cmd_head  = cmd_mem[cmd_rd_ptr];

   assign rsp_valid = (rsp_count != '0);
   assign rsp_data  = rsp_mem[rsp_rd_ptr];
   assign rsp_pop   = rsp_valid && rsp_ready;

   assign res_expected   = host_out_valid && (outstanding != '0);
   assign res_unexpected = host_out_valid && (outstanding == '0);
   assign rsp_push       = res_expected;

   // Ops in flight plus results not yet consumed may never exceed the
   // response queue size, so an expected result always finds a free slot.
   assign credit_used = OW1'(outstanding) + OW1'(rsp_count);
   assign eligible    = (cmd_count != '0) && (credit_used < OW1'(RSP_DEPTH));

   // An issue or expected result this cycle would clear the counter instead.
   assign tmo_hit = (outstanding != '0) && !res_expected &&
                    (tmo_cnt == TW'(TIMEOUT - 1));

   // Command queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_count  <= '0;
      end else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + CP'(1);
         if (issue)    cmd_rd_ptr <= cmd_rd_ptr + CP'(1);
         cmd_count <= cmd_count + CW'(cmd_push) - CW'(issue);
      end
   end

   // Command queue storage
   always_ff @(posedge clk) begin
      if (cmd_push) cmd_mem[cmd_wr_ptr] <= {cmd_ctrl, cmd_b, cmd_a};
   end

   // Response queue pointers and occupancy
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_wr_ptr <= '0;
         rsp_rd_ptr <= '0;
         rsp_count  <= '0;
      end else begin
         if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + RP'(1);
         if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + RP'(1);
         rsp_count <= rsp_count + OW'(rsp_push) - OW'(rsp_pop);
      end
   end

   // Response queue storage
   always_ff @(posedge clk) begin
      if (rsp_push) rsp_mem[rsp_wr_ptr] <= host_out_a;
   end

   // Issue FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Issue FSM next state and issue decision. The last GAP cycle may issue
   // directly, so exactly ISSUE_GAP idle cycles separate valid pulses.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      tmo_fire  = 1'b0;
      case (state)
         IDLE: begin
            if (eligible) begin
               issue     = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (ISSUE_GAP > 0) begin
               state_nxt = GAP;
            end else if (eligible) begin
               issue     = 1'b1;
               state_nxt = SEND;
            end else begin
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (gap_cnt == '0) begin
               if (eligible) begin
                  issue     = 1'b1;
                  state_nxt = SEND;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         ERR: begin
            if (err_clr) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit && !issue) begin
         tmo_fire  = 1'b1;
         state_nxt = ERR;
      end
   end

   // Forced idle countdown, loaded while the valid pulse is on the port
   always_ff @(posedge clk) begin
      if (rst)                 gap_cnt <= '0;
      else if (state == SEND)  gap_cnt <= GW'(GAP_LOAD);
      else if (gap_cnt != '0)  gap_cnt <= gap_cnt - GW'(1);
   end

   // Host port drive: operands hold their last issued value between pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         host_in_valid <= 1'b0;
         host_in_a     <= '0;
         host_in_b     <= '0;
         host_in_ctrl  <= '0;
      end else begin
         host_in_valid <= issue;
         if (issue) begin
            host_in_a    <= cmd_head[63:0];
            host_in_b    <= cmd_head[127:64];
            host_in_ctrl <= cmd_head[143:128];
         end
      end
   end

   // In-flight count, timeout counter and sticky error flags
   always_ff @(posedge clk) begin
      if (rst) begin
         outstanding <= '0;
         tmo_cnt     <= '0;
         err         <= '0;
      end else begin
         if (tmo_fire) outstanding <= '0;
         else          outstanding <= outstanding + OW'(issue) - OW'(res_expected);

         if (tmo_fire || issue || res_expected || (outstanding == '0))
            tmo_cnt <= '0;
         else
            tmo_cnt <= tmo_cnt + TW'(1);

         if (err_clr) begin
            err <= '0;
         end else begin
            if (tmo_fire)       err[0] <= 1'b1;
            if (res_unexpected) err[1] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_tile_host_driver.sv
// Directed bench for alu_tile_host_driver: one instance with back-to-back
// issue and a short timeout, one with a two-cycle issue gap.
module tb_alu_tile_host_driver;

   logic        clk = 1'b0;
   logic        rst;
   always #5 clk = ~clk;

   // main instance
   logic        cmd_valid, cmd_ready;
   logic [63:0] cmd_a, cmd_b;
   logic [15:0] cmd_ctrl;
   logic [63:0] host_in_a, host_in_b;
   logic [15:0] host_in_ctrl;
   logic        host_in_valid;
   logic [63:0] host_out_a;
   logic        host_out_valid;
   logic        rsp_valid, rsp_ready;
   logic [63:0] rsp_data;
   logic [2:0]  outstanding;
   logic [1:0]  err;
   logic        err_clr;

   // gap instance
   logic        g_cmd_valid, g_cmd_ready;
   logic [63:0] g_cmd_a, g_cmd_b;
   logic [15:0] g_cmd_ctrl;
   logic [63:0] g_host_in_a, g_host_in_b;
   logic [15:0] g_host_in_ctrl;
   logic        g_host_in_valid;
   logic [63:0] g_host_out_a;
   logic        g_host_out_valid;
   logic        g_rsp_valid, g_rsp_ready;
   logic [63:0] g_rsp_data;
   logic [2:0]  g_outstanding;
   logic [1:0]  g_err;
   logic        g_err_clr;

   alu_tile_host_driver #(.CMD_DEPTH(4), .RSP_DEPTH(4), .ISSUE_GAP(0), .TIMEOUT(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_ctrl(cmd_ctrl),
      .host_in_a(host_in_a), .host_in_b(host_in_b),
      .host_in_ctrl(host_in_ctrl), .host_in_valid(host_in_valid),
      .host_out_a(host_out_a), .host_out_valid(host_out_valid),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .outstanding(outstanding), .err(err), .err_clr(err_clr)
   );

   alu_tile_host_driver #(.CMD_DEPTH(4), .RSP_DEPTH(4), .ISSUE_GAP(2), .TIMEOUT(1024)) dut_g (
      .clk(clk), .rst(rst),
      .cmd_valid(g_cmd_valid), .cmd_ready(g_cmd_ready),
      .cmd_a(g_cmd_a), .cmd_b(g_cmd_b), .cmd_ctrl(g_cmd_ctrl),
      .host_in_a(g_host_in_a), .host_in_b(g_host_in_b),
      .host_in_ctrl(g_host_in_ctrl), .host_in_valid(g_host_in_valid),
      .host_out_a(g_host_out_a), .host_out_valid(g_host_out_valid),
      .rsp_valid(g_rsp_valid), .rsp_ready(g_rsp_ready), .rsp_data(g_rsp_data),
      .outstanding(g_outstanding), .err(g_err), .err_clr(g_err_clr)
   );

   int checks = 0;
   int fails  = 0;

   // pulse / error-edge timestamps, written only here
   int   cyc = 0;
   int   p_n = 0;
   int   p_cyc [64];
   int   g_n = 0;
   int   g_cyc [64];
   int   err0_cyc = -1;
   logic err0_q = 1'b0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (host_in_valid) begin
         if (p_n < 64) p_cyc[p_n] <= cyc;
         p_n <= p_n + 1;
      end
      if (g_host_in_valid) begin
         if (g_n < 64) g_cyc[g_n] <= cyc;
         g_n <= g_n + 1;
      end
      if (err[0] && !err0_q) err0_cyc <= cyc;
      err0_q <= err[0];
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
      int t;
      cmd_a = a; cmd_b = b; cmd_ctrl = c; cmd_valid = 1'b1;
      t = 0;
      while (!cmd_ready && t < 20) begin
         tick();
         t++;
      end
      if (!cmd_ready) check("push_wait", {63'd0, cmd_ready}, 64'd1);
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic result(input logic [63:0] v);
      host_out_a = v; host_out_valid = 1'b1;
      tick();
      host_out_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int          base;
      int          t;
      logic [63:0] exp_q [4];

      rst = 1'b1;
      cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_ctrl = 0;
      host_out_a = 0; host_out_valid = 0; rsp_ready = 0; err_clr = 0;
      g_cmd_valid = 0; g_cmd_a = 0; g_cmd_b = 0; g_cmd_ctrl = 0;
      g_host_out_a = 0; g_host_out_valid = 0; g_rsp_ready = 0; g_err_clr = 0;
      tick();
      tick();

      // reset state
      check("rst_cmd_ready",   64'(cmd_ready), 64'd1);
      check("rst_rsp_valid",   64'(rsp_valid), 64'd0);
      check("rst_hv",          64'(host_in_valid), 64'd0);
      check("rst_host_a",      host_in_a, 64'd0);
      check("rst_outstanding", 64'(outstanding), 64'd0);
      check("rst_err",         64'(err), 64'd0);
      rst = 1'b0;

      // single op latency: accepted cycle N, valid at N+2
      cmd_a = 64'd5; cmd_b = 64'd3; cmd_ctrl = 16'h0001; cmd_valid = 1'b1;
      tick();
      cmd_valid = 1'b0;
      check("lat_n1_hv", 64'(host_in_valid), 64'd0);
      tick();
      check("lat_n2_hv",   64'(host_in_valid), 64'd1);
      check("lat_n2_a",    host_in_a, 64'd5);
      check("lat_n2_b",    host_in_b, 64'd3);
      check("lat_n2_ctrl", 64'(host_in_ctrl), 64'h1);
      check("lat_n2_out",  64'(outstanding), 64'd1);
      tick();
      check("lat_n3_hv",   64'(host_in_valid), 64'd0);
      check("hold_a",      host_in_a, 64'd5);
      result(64'd8);
      check("res_rsp_valid", 64'(rsp_valid), 64'd1);
      check("res_rsp_data",  rsp_data, 64'd8);
      check("res_out",       64'(outstanding), 64'd0);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      check("pop_empty", 64'(rsp_valid), 64'd0);

      // credit limit: 6 commands, no results, no pops
      base = p_n;
      for (int i = 0; i < 6; i++) push(64'(100 + i), 64'(i), 16'h2);
      repeat (3) tick();
      check("credit_issues", 64'(p_n - base), 64'd4);
      check("credit_out",    64'(outstanding), 64'd4);
      check("credit_last_a", host_in_a, 64'd103);
      for (int i = 0; i < 4; i++) result(64'(200 + i));
      check("full_out",  64'(outstanding), 64'd0);
      check("full_head", rsp_data, 64'd200);
      repeat (3) tick();
      check("full_no_issue", 64'(p_n - base), 64'd4);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      check("pop_head", rsp_data, 64'd201);
      repeat (3) tick();
      check("pop_frees_issue", 64'(p_n - base), 64'd5);
      check("pop_issue_a",     host_in_a, 64'd104);
      result(64'd300);
      exp_q[0] = 64'd201; exp_q[1] = 64'd202; exp_q[2] = 64'd203; exp_q[3] = 64'd300;
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("drain_order", rsp_data, exp_q[i]);
         tick();
      end
      rsp_ready = 1'b0;
      repeat (2) tick();
      check("sixth_issue", 64'(p_n - base), 64'd6);
      check("sixth_a",     host_in_a, 64'd105);
      check("sixth_out",   64'(outstanding), 64'd1);
      result(64'd301);
      check("sixth_rsp", rsp_data, 64'd301);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      check("sixth_empty", 64'(rsp_valid), 64'd0);

      // back-to-back issue with no gap
      base = p_n;
      for (int i = 0; i < 3; i++) push(64'(48 + i), 64'd0, 16'h3);
      repeat (4) tick();
      check("b2b_count", 64'(p_n - base), 64'd3);
      check("b2b_d1",    64'(p_cyc[base + 1] - p_cyc[base]), 64'd1);
      check("b2b_d2",    64'(p_cyc[base + 2] - p_cyc[base + 1]), 64'd1);
      // results arriving while the consumer pops every cycle
      for (int i = 0; i < 3; i++) begin
         host_out_a = 64'(64 + i); host_out_valid = 1'b1; rsp_ready = 1'b1;
         tick();
         check("pushpop_head", rsp_data, 64'(64 + i));
      end
      host_out_valid = 1'b0;
      tick();
      rsp_ready = 1'b0;
      check("pushpop_empty", 64'(rsp_valid), 64'd0);
      check("pushpop_out",   64'(outstanding), 64'd0);

      // two-cycle issue gap
      base = g_n;
      for (int i = 0; i < 3; i++) begin
         g_cmd_a = 64'(80 + i); g_cmd_valid = 1'b1;
         tick();
      end
      g_cmd_valid = 1'b0;
      repeat (12) tick();
      check("gap_count", 64'(g_n - base), 64'd3);
      check("gap_d1",    64'(g_cyc[base + 1] - g_cyc[base]), 64'd3);
      check("gap_d2",    64'(g_cyc[base + 2] - g_cyc[base + 1]), 64'd3);
      check("gap_last_a", g_host_in_a, 64'd82);
      check("gap_out",   64'(g_outstanding), 64'd3);

      // timeout of a lost result
      base = p_n;
      push(64'h11, 64'd0, 16'h4);
      t = 0;
      while (p_n == base && t < 10) begin tick(); t++; end
      check("tmo_issue", 64'(p_n - base), 64'd1);
      t = 0;
      while (!err[0] && t < 40) begin tick(); t++; end
      @(negedge clk); #1;
      check("tmo_err",   64'(err), 64'b01);
      check("tmo_out",   64'(outstanding), 64'd0);
      check("tmo_delay", 64'(err0_cyc - p_cyc[base]), 64'd16);
      push(64'h22, 64'd0, 16'h5);
      repeat (4) tick();
      check("err_no_issue", 64'(p_n - base), 64'd1);
      result(64'hdead);
      check("late_err",  64'(err), 64'b11);
      check("late_rsp",  64'(rsp_valid), 64'd0);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      check("clr_err", 64'(err), 64'd0);
      repeat (3) tick();
      check("resume_issue", 64'(p_n - base), 64'd2);
      check("resume_a",     host_in_a, 64'h22);
      check("resume_out",   64'(outstanding), 64'd1);
      result(64'h99);
      rsp_ready = 1'b1; tick(); rsp_ready = 1'b0;
      check("resume_drain", 64'(rsp_valid), 64'd0);

      // unexpected result while idle; err_clr beats same-cycle set
      result(64'h77);
      check("unexp_err", 64'(err), 64'b10);
      check("unexp_rsp", 64'(rsp_valid), 64'd0);
      check("unexp_out", 64'(outstanding), 64'd0);
      host_out_a = 64'h78; host_out_valid = 1'b1; err_clr = 1'b1;
      tick();
      host_out_valid = 1'b0; err_clr = 1'b0;
      check("clr_wins", 64'(err), 64'd0);

      // reset in the middle of traffic
      result(64'h1);
      push(64'h60, 64'd0, 16'h6);
      push(64'h61, 64'd0, 16'h6);
      repeat (3) tick();
      result(64'h70);
      result(64'h71);
      for (int i = 0; i < 5; i++) push(64'(128 + i), 64'd0, 16'h7);
      repeat (3) tick();
      check("pre_rst_out", 64'(outstanding), 64'd2);
      check("pre_rst_rsp", 64'(rsp_valid), 64'd1);
      check("pre_rst_err", 64'(err), 64'b10);
      rst = 1'b1;
      tick();
      check("mid_rst_out",   64'(outstanding), 64'd0);
      check("mid_rst_rsp",   64'(rsp_valid), 64'd0);
      check("mid_rst_err",   64'(err), 64'd0);
      check("mid_rst_ready", 64'(cmd_ready), 64'd1);
      check("mid_rst_hv",    64'(host_in_valid), 64'd0);
      rst = 1'b0;
      base = p_n;
      repeat (5) tick();
      check("rst_discard", 64'(p_n - base), 64'd0);
      result(64'h72);
      check("post_rst_unexp", 64'(err), 64'b10);
      check("post_rst_rsp",   64'(rsp_valid), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
